ecc_54_enc_pipe: RTL and testbench



---
 rtl/ecc_54_enc_pipe.sv | 111 +++++++++++
 tb/tb_ecc_54_enc_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_54_enc_pipe.sv
// ecc_54_enc_pipe: SECDED (54 data + 7 check) encoder pipeline with output/skid buffering and one-shot error injection
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data, in_valid, in_ready   input word handshake (in_ready is registered)
//   bypass                     per-word: zero parity field, no injection
//   out_cw, out_valid, out_ready  registered codeword {parity[6:0], data[53:0]}
//   err_inj_req/dbit/pos       arm a single- or double-bit flip on the next encoded word
//   err_inj_armed, err_inj_done   injection armed / pulse when the injected word is taken
//   word_cnt                   accepted-word counter, wraps
module ecc_54_enc_pipe #(
    parameter int DATA_WIDTH   = 54,
    parameter int PARITY_WIDTH = 7,
    parameter int CW_WIDTH     = 61
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  bypass,
    output logic [CW_WIDTH-1:0]   out_cw,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  err_inj_req,
    input  logic                  err_inj_dbit,
    input  logic [5:0]            err_inj_pos,
    output logic                  err_inj_armed,
    output logic                  err_inj_done,
    output logic [15:0]           word_cnt
);
    // Data bit i sits at the (i+1)-th non-power-of-two position >= 3; parity 6
    // covers even-weight positions so every data column has odd weight.
    function automatic logic [DATA_WIDTH-1:0] par_mask(input int k);
        logic [DATA_WIDTH-1:0] m = '0;
        logic [5:0] p;
        int n = 0;
        for (int v = 3; v < 64; v++) begin
            p = 6'(v);
            if ((p & (p - 6'd1)) != 6'd0 && n < DATA_WIDTH) begin
                m[n] = (k < 6) ? p[k] : ~^p;
                n++;
            end
        end
        return m;
    endfunction

    logic [PARITY_WIDTH-1:0] parity;
    for (genvar k = 0; k < PARITY_WIDTH; k++) begin : g_par
        localparam logic [DATA_WIDTH-1:0] MASK = par_mask(k);
        assign parity[k] = ^(in_data & MASK);
    end

    logic                skid_valid;
    logic [CW_WIDTH-1:0] skid_cw;
    logic                inj_dbit;
    logic [5:0]          inj_pos;
    logic [5:0]          nxt_pos;
    logic [CW_WIDTH-1:0] flip;
    logic [CW_WIDTH-1:0] new_cw;
    logic                accept;
    logic                fire;
    logic                out_free;

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign fire     = accept && err_inj_armed && !bypass;
    assign out_free = !out_valid || out_ready;

    always_comb begin
        nxt_pos = (inj_pos == 6'd60) ? 6'd0 : inj_pos + 6'd1;
        flip    = (CW_WIDTH'(1) << inj_pos) | (inj_dbit ? CW_WIDTH'(1) << nxt_pos : '0);
        new_cw  = bypass ? {{PARITY_WIDTH{1'b0}}, in_data}
                         : {parity, in_data} ^ (err_inj_armed ? flip : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cw        <= '0;
            out_valid     <= 1'b0;
            skid_cw       <= '0;
            skid_valid    <= 1'b0;
            err_inj_armed <= 1'b0;
            err_inj_done  <= 1'b0;
            inj_dbit      <= 1'b0;
            inj_pos       <= '0;
            word_cnt      <= '0;
        end else begin
            word_cnt     <= word_cnt + {15'd0, accept};
            err_inj_done <= fire;
            if (fire) begin
                err_inj_armed <= 1'b0;
            end else if (err_inj_req && !err_inj_armed) begin
                err_inj_armed <= 1'b1;
                inj_dbit      <= err_inj_dbit;
                inj_pos       <= (err_inj_pos > 6'd60) ? 6'd60 : err_inj_pos;
            end
            // A full skid blocks accepts, so draining it never races a new word.
            if (out_free) begin
                out_valid  <= skid_valid || accept;
                skid_valid <= 1'b0;
                if (skid_valid)
                    out_cw <= skid_cw;
                else if (accept)
                    out_cw <= new_cw;
            end else if (accept) begin
                skid_cw    <= new_cw;
                skid_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ecc_54_enc_pipe.sv
// tb_ecc_54_enc_pipe: directed bench for the 54/7 SECDED encoder pipeline
module tb_ecc_54_enc_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [53:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        bypass = 1'b0;
    logic [60:0] out_cw;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        err_inj_req = 1'b0;
    logic        err_inj_dbit = 1'b0;
    logic [5:0]  err_inj_pos = '0;
    logic        err_inj_armed;
    logic        err_inj_done;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    ecc_54_enc_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bypass(bypass), .out_cw(out_cw), .out_valid(out_valid), .out_ready(out_ready),
        .err_inj_req(err_inj_req), .err_inj_dbit(err_inj_dbit), .err_inj_pos(err_inj_pos),
        .err_inj_armed(err_inj_armed), .err_inj_done(err_inj_done), .word_cnt(word_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [5:0] pos_tab[54];

    typedef struct {
        logic [53:0] data;
        logic        byp;
        logic [6:0]  par;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] model_par(input logic [53:0] d);
        logic [6:0] p = '0;
        for (int i = 0; i < 54; i++)
            if (d[i]) begin
                p[5:0] = p[5:0] ^ pos_tab[i];
                p[6]   = p[6] ^ ~^pos_tab[i];
            end
        return p;
    endfunction

    function automatic logic [60:0] cw_of(input logic [53:0] d, input logic b);
        return b ? {7'd0, d} : {model_par(d), d};
    endfunction

    // Read-side reference checker: returns {sbit_err, dbit_err, corrected}
    function automatic logic [62:0] check_cw(input logic [60:0] cw);
        logic [6:0]  syn;
        logic [60:0] c = cw;
        logic        s = 1'b0;
        logic        db = 1'b0;
        syn = model_par(cw[53:0]) ^ cw[60:54];
        if (syn != 7'd0) begin
            if (^syn) begin
                s = 1'b1;
                for (int k = 0; k < 7; k++)
                    if (syn == 7'(1 << k)) c[54+k] = ~c[54+k];
                for (int i = 0; i < 54; i++)
                    if (syn == {~^pos_tab[i], pos_tab[i]}) c[i] = ~c[i];
            end else begin
                db = 1'b1;
            end
        end
        return {s, db, c};
    endfunction

    task automatic send(input logic [53:0] d, input logic b);
        @(negedge clk);
        in_data = d; bypass = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; bypass = 1'b0;
    endtask

    task automatic arm(input logic db, input logic [5:0] p);
        @(negedge clk);
        err_inj_req = 1'b1; err_inj_dbit = db; err_inj_pos = p;
        @(negedge clk);
        err_inj_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [53:0] words[100];
    logic [62:0] r;
    logic [53:0] d;

    initial begin
        int n = 0;
        for (int v = 3; n < 54; v++)
            if ($countones(v) != 1) begin
                pos_tab[n] = 6'(v);
                n++;
            end
        vecs[0] = '{54'h1, 1'b0, 7'h43};
        vecs[1] = '{54'h20000000000000, 1'b0, 7'h7C};
        vecs[2] = '{54'h0, 1'b0, 7'h00};
        vecs[3] = '{54'h2, 1'b0, 7'h45};
        vecs[4] = '{54'h4, 1'b0, 7'h46};
        vecs[5] = '{54'h8, 1'b0, 7'h07};
        vecs[6] = '{54'hF, 1'b0, 7'h47};
        vecs[7] = '{54'h3FFFFFFFFFFFFF, 1'b1, 7'h00};

        // reset state
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_cw", 64'(out_cw), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_armed", 64'(err_inj_armed), 64'd0);
        chk("rst_done", 64'(err_inj_done), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // encoding table
        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].byp);
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_cw", 64'(out_cw), 64'({vecs[i].par, vecs[i].data}));
        end
        send(54'h3FFFFFFFFFFFFF, 1'b0);
        chk("ones_cw", 64'(out_cw), 64'(cw_of(54'h3FFFFFFFFFFFFF, 1'b0)));
        r = check_cw(out_cw);
        chk("ones_noerr", 64'(r[62:61]), 64'd0);

        // back-to-back stream
        do_reset();
        for (int i = 0; i < 100; i++) words[i] = 54'({$urandom, $urandom});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("strm_valid", 64'(out_valid), 64'd1);
                chk("strm_cw", 64'(out_cw), 64'(cw_of(words[i-1], 1'b0)));
            end
            in_data = words[i]; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("strm_last", 64'(out_cw), 64'(cw_of(words[99], 1'b0)));
        chk("strm_cnt", 64'(word_cnt), 64'd100);

        // backpressure
        do_reset();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 54'h111;
        @(negedge clk);
        chk("bp_out0", 64'(out_cw), 64'(cw_of(54'h111, 1'b0)));
        chk("bp_rdy1", 64'(in_ready), 64'd1);
        in_data = 54'h222;
        @(negedge clk);
        chk("bp_rdy2", 64'(in_ready), 64'd0);
        in_data = 54'h333;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_cw", 64'(out_cw), 64'(cw_of(54'h111, 1'b0)));
            chk("bp_hold_rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain1", 64'(out_cw), 64'(cw_of(54'h222, 1'b0)));
        chk("bp_drain1_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_drain2", 64'(out_cw), 64'(cw_of(54'h333, 1'b0)));
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_cnt", 64'(word_cnt), 64'd3);

        // single injection at bit 5
        d = 54'h123456789ABCD;
        arm(1'b0, 6'd5);
        chk("s_armed", 64'(err_inj_armed), 64'd1);
        send(d, 1'b0);
        chk("s_cw", 64'(out_cw), 64'(cw_of(d, 1'b0) ^ (61'd1 << 5)));
        chk("s_done", 64'(err_inj_done), 64'd1);
        chk("s_disarm", 64'(err_inj_armed), 64'd0);
        r = check_cw(out_cw);
        chk("s_sbit", 64'(r[62:61]), 64'd2);
        chk("s_corr", 64'(r[60:0]), 64'(cw_of(d, 1'b0)));
        @(negedge clk);
        chk("s_done_once", 64'(err_inj_done), 64'd0);
        send(d, 1'b0);
        chk("s_next_clean", 64'(out_cw), 64'(cw_of(d, 1'b0)));

        // double injection at bit 60 wraps to bit 0; repeat request ignored
        d = 54'h2AAAA5555CCCC;
        arm(1'b1, 6'd60);
        arm(1'b0, 6'd3);
        chk("d_armed", 64'(err_inj_armed), 64'd1);
        send(d, 1'b0);
        chk("d_cw", 64'(out_cw), 64'(cw_of(d, 1'b0) ^ (61'd1 << 60) ^ 61'd1));
        r = check_cw(out_cw);
        chk("d_dbit", 64'(r[62:61]), 64'd1);
        chk("d_disarm", 64'(err_inj_armed), 64'd0);

        // bypass word keeps injection armed; position >= 61 clamps to 60
        d = 54'h0F0F0F0F0F0F0;
        arm(1'b0, 6'd63);
        send(d, 1'b1);
        chk("b_cw", 64'(out_cw), 64'(cw_of(d, 1'b1)));
        chk("b_armed", 64'(err_inj_armed), 64'd1);
        chk("b_nodone", 64'(err_inj_done), 64'd0);
        send(d, 1'b0);
        chk("clamp_cw", 64'(out_cw), 64'(cw_of(d, 1'b0) ^ (61'd1 << 60)));
        chk("clamp_done", 64'(err_inj_done), 64'd1);

        // request in the accept cycle arms for the following word
        @(negedge clk);
        in_data = d; in_valid = 1'b1;
        err_inj_req = 1'b1; err_inj_dbit = 1'b0; err_inj_pos = 6'd10;
        @(negedge clk);
        in_valid = 1'b0; err_inj_req = 1'b0;
        chk("same_cyc_clean", 64'(out_cw), 64'(cw_of(d, 1'b0)));
        chk("same_cyc_armed", 64'(err_inj_armed), 64'd1);
        send(d, 1'b0);
        chk("same_cyc_next", 64'(out_cw), 64'(cw_of(d, 1'b0) ^ (61'd1 << 10)));

        // reset mid-stream with two words buffered and injection armed
        repeat (2) @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 54'hAAA;
        @(negedge clk);
        in_data = 54'hBBB;
        @(negedge clk);
        in_valid = 1'b0;
        arm(1'b0, 6'd7);
        chk("mr_full", 64'(in_ready), 64'd0);
        chk("mr_armed", 64'(err_inj_armed), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_rdy", 64'(in_ready), 64'd1);
        chk("mr_armed0", 64'(err_inj_armed), 64'd0);
        chk("mr_cnt", 64'(word_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        send(54'hCCC, 1'b0);
        chk("mr_first_valid", 64'(out_valid), 64'd1);
        chk("mr_first_cw", 64'(out_cw), 64'(cw_of(54'hCCC, 1'b0)));
        chk("mr_first_done", 64'(err_inj_done), 64'd0);
        @(negedge clk);
        chk("mr_no_stale", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
